// File: rtl/aes128_encrypt_iter.sv
// aes128_encrypt_iter: iterative AES-128 encryption, one full round per clock.
// The block takes a plaintext and the 11 expanded round keys, runs the initial
// AddRoundKey on the accepting edge and then 10 rounds, and returns the
// ciphertext over a valid/ready pair. Only one block is in flight at a time.
// aes_sbox: the AES byte S-box, built from the GF(2^8) inverse and the affine map.

module aes_sbox (
   input  logic [7:0] i_byte,
   output logic [7:0] o_byte
);

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // The inverse is a^254 = a^2 * a^4 * ... * a^128. A zero input gives zero,
   // which is exactly the value the S-box definition assigns to it.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] acc;
      sq  = a;
      acc = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq  = gf_mul(sq, sq);
         acc = gf_mul(acc, sq);
      end
      return acc;
   endfunction

   logic [7:0] w_inv;

   // Inverse followed by the affine transform (four left rotations plus 0x63).
   always_comb begin
      w_inv  = gf_inv(i_byte);
      o_byte = w_inv
             ^ {w_inv[6:0], w_inv[7]}
             ^ {w_inv[5:0], w_inv[7:6]}
             ^ {w_inv[4:0], w_inv[7:5]}
             ^ {w_inv[3:0], w_inv[7:4]}
             ^ 8'h63;
   end

endmodule

module aes128_encrypt_iter #(
   parameter int NR = 10
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [127:0]  plaintext,
   input  logic [1407:0] round_keys,
   output logic          busy,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [127:0]  ciphertext
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [3:0] LP_LAST = 4'(NR);

   state_t       r_state;
   state_t       w_state_nxt;
   logic [127:0] r_st;
   logic [127:0] w_st_nxt;
   logic [3:0]   r_rnd;
   logic [3:0]   w_rnd_nxt;
   logic         w_accept;

   logic [127:0] w_rk_cur;
   logic [127:0] w_load;
   logic [127:0] w_round_full;
   logic [127:0] w_round_last;
   logic [7:0]   w_st_b [16];
   logic [7:0]   w_sb_b [16];
   logic [7:0]   w_sr_b [16];
   logic [7:0]   w_mc_b [16];

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Select the key of the round in progress; counts past the last round select zero.
   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      w_rk_cur = '0;
      for (int i = 0; i <= NR; i++) begin
         if (r_rnd == 4'(i)) w_rk_cur = round_keys[128*i +: 128];
      end
   end

   assign w_load     = plaintext ^ round_keys[127:0];
   assign ciphertext = r_st;

   // Split the state into FIPS-197 byte order (byte 0 is the top byte).
   always_comb begin
      for (int k = 0; k < 16; k++) w_st_b[k] = r_st[127-8*k -: 8];
   end

   genvar g;
   generate
      for (g = 0; g < 16; g++) begin : g_sbox
         aes_sbox u_sbox (
            .i_byte (w_st_b[g]),
            .o_byte (w_sb_b[g])
         );
      end
   endgenerate

   // ShiftRows, MixColumns and AddRoundKey; the last round bypasses MixColumns.
   always_comb begin
      // Byte 4c+r sits in row r, column c; row r rotates left by r columns.
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            w_sr_b[4*c+r] = w_sb_b[4*((c+r)%4)+r];
         end
      end
      for (int c = 0; c < 4; c++) begin
         w_mc_b[4*c+0] = xtime(w_sr_b[4*c+0]) ^ xtime(w_sr_b[4*c+1]) ^ w_sr_b[4*c+1]
                       ^ w_sr_b[4*c+2] ^ w_sr_b[4*c+3];
         w_mc_b[4*c+1] = w_sr_b[4*c+0] ^ xtime(w_sr_b[4*c+1]) ^ xtime(w_sr_b[4*c+2])
                       ^ w_sr_b[4*c+2] ^ w_sr_b[4*c+3];
         w_mc_b[4*c+2] = w_sr_b[4*c+0] ^ w_sr_b[4*c+1] ^ xtime(w_sr_b[4*c+2])
                       ^ xtime(w_sr_b[4*c+3]) ^ w_sr_b[4*c+3];
         w_mc_b[4*c+3] = xtime(w_sr_b[4*c+0]) ^ w_sr_b[4*c+0] ^ w_sr_b[4*c+1]
                       ^ w_sr_b[4*c+2] ^ xtime(w_sr_b[4*c+3]);
      end
      w_round_full = '0;
      w_round_last = '0;
      for (int k = 0; k < 16; k++) begin
         w_round_full[127-8*k -: 8] = w_mc_b[k] ^ w_rk_cur[127-8*k -: 8];
         w_round_last[127-8*k -: 8] = w_sr_b[k] ^ w_rk_cur[127-8*k -: 8];
      end
   end

   // Handshake outputs decoded from the state, then next-state and datapath values.
   always_comb begin
      w_state_nxt = r_state;
      w_st_nxt    = r_st;
      w_rnd_nxt   = r_rnd;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      busy        = 1'b0;
      w_accept    = 1'b0;

      case (r_state)
         S_IDLE: in_ready = ~rst;
         S_RUN:  busy = 1'b1;
         S_DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            in_ready  = out_ready & ~rst;
         end
         default: ;
      endcase

      if (r_rnd > LP_LAST) begin
         // Unreachable round count: recover to a clean idle state.
         w_state_nxt = S_IDLE;
         w_rnd_nxt   = 4'd0;
      end else begin
         case (r_state)
            S_IDLE: w_accept = in_valid;
            S_RUN: begin
               if (r_rnd == LP_LAST) begin
                  w_st_nxt    = w_round_last;
                  w_rnd_nxt   = 4'd0;
                  w_state_nxt = S_DONE;
               end else begin
                  w_st_nxt  = w_round_full;
                  w_rnd_nxt = r_rnd + 4'd1;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  if (in_valid) w_accept = 1'b1;
                  else          w_state_nxt = S_IDLE;
               end
            end
            default: begin
               w_state_nxt = S_IDLE;
               w_rnd_nxt   = 4'd0;
            end
         endcase
      end

      // A new block loads the initial AddRoundKey result and starts at round 1.
      if (w_accept) begin
         w_state_nxt = S_RUN;
         w_st_nxt    = w_load;
         w_rnd_nxt   = 4'd1;
      end
   end

   // FSM state register.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Round state and round counter.
   // NOTE: the state register is reset so the ciphertext port reads zero after reset and an aborted block leaves nothing behind.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_st  <= '0;
         r_rnd <= '0;
      end else begin
         r_st  <= w_st_nxt;
         r_rnd <= w_rnd_nxt;
      end
   end

endmodule

// File: tb/tb_aes128_encrypt_iter.sv
// Self-checking bench for aes128_encrypt_iter. A behavioural AES-128 model
// (S-box from a brute-force inverse search, key expansion, 4x4 state matrix)
// supplies every expected ciphertext; FIPS-197 vectors are checked as constants.
module tb_aes128_encrypt_iter;

   localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [127:0]  plaintext;
   logic [1407:0] round_keys;
   logic          busy;
   logic          out_valid;
   logic          out_ready;
   logic [127:0]  ciphertext;

   int n_tests = 0;
   int n_fail  = 0;
   int proto_err = 0;
   logic [1407:0] mon_prev_rk;
   logic [7:0] sbox_tbl [256];

   aes128_encrypt_iter #(.NR(10)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .plaintext  (plaintext),
      .round_keys (round_keys),
      .busy       (busy),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .ciphertext (ciphertext)
   );

   always #5 clk = ~clk;

   // Round keys must not move while a block is still being computed.
   always @(posedge clk) begin
      if (busy === 1'b1 && out_valid === 1'b0 && round_keys !== mon_prev_rk)
         proto_err <= proto_err + 1;
      mon_prev_rk <= round_keys;
   end

   // ---------------- reference model ----------------
   function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   task automatic build_sbox();
      logic [7:0] inv;
      logic [7:0] cst;
      logic [7:0] s;
      cst = 8'h63;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (m_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         for (int i = 0; i < 8; i++)
            s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ cst[i];
         sbox_tbl[x] = s;
      end
   endtask

   function automatic logic [1407:0] m_expand(input logic [127:0] key);
      logic [31:0]   w [44];
      logic [31:0]   t;
      logic [7:0]    rcon;
      logic [1407:0] rk;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      rcon = 8'h01;
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sbox_tbl[t[31:24]], sbox_tbl[t[23:16]], sbox_tbl[t[15:8]], sbox_tbl[t[7:0]]}
              ^ {rcon, 24'h0};
            rcon = m_mul(rcon, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) rk[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      return rk;
   endfunction

   function automatic logic [127:0] m_encrypt(input logic [127:0] pt, input logic [1407:0] rk);
      logic [7:0]   s [4][4];
      logic [7:0]   t [4][4];
      logic [127:0] k;
      logic [127:0] ct;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) s[r][c] = pt[127-8*(4*c+r) -: 8];
      for (int rnd = 0; rnd <= 10; rnd++) begin
         k = rk[128*rnd +: 128];
         if (rnd > 0) begin
            for (int r = 0; r < 4; r++)
               for (int c = 0; c < 4; c++) t[r][c] = sbox_tbl[s[r][(c+r)%4]];
            s = t;
            if (rnd < 10) begin
               for (int c = 0; c < 4; c++) begin
                  t[0][c] = m_mul(s[0][c], 8'h02) ^ m_mul(s[1][c], 8'h03) ^ s[2][c] ^ s[3][c];
                  t[1][c] = s[0][c] ^ m_mul(s[1][c], 8'h02) ^ m_mul(s[2][c], 8'h03) ^ s[3][c];
                  t[2][c] = s[0][c] ^ s[1][c] ^ m_mul(s[2][c], 8'h02) ^ m_mul(s[3][c], 8'h03);
                  t[3][c] = m_mul(s[0][c], 8'h03) ^ s[1][c] ^ s[2][c] ^ m_mul(s[3][c], 8'h02);
               end
               s = t;
            end
         end
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) s[r][c] = s[r][c] ^ k[127-8*(4*c+r) -: 8];
      end
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) ct[127-8*(4*c+r) -: 8] = s[r][c];
      return ct;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // ---------------- drivers ----------------
   // Offer a block and return just after the accepting rising edge.
   task automatic do_accept(input logic [127:0] pt, input logic [1407:0] rk);
      int guard;
      guard = 0;
      plaintext  = pt;
      round_keys = rk;
      in_valid   = 1'b1;
      #1;
      while (in_ready !== 1'b1 && guard < 50) begin
         @(negedge clk); #1;
         guard++;
      end
      n_tests++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL accept_ready: in_ready=%b, expected 1", in_ready);
      end
      @(posedge clk);
   endtask

   // Count falling edges after the accepting edge until out_valid is seen.
   // The negedge right after the accepting edge counts as 1, so out_valid
   // first shows at count 11 (10 round edges, then visible in the 11th clock).
   task automatic wait_out(input bit drop, output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
         if (drop) in_valid = 1'b0;
      end while (out_valid !== 1'b1 && cyc < 60);
   endtask

   task automatic do_handshake();
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      plaintext = '0; round_keys = '0;
      repeat (2) @(negedge clk);
      n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b, expected 0", in_ready); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", busy); end
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, expected 0", out_valid); end
      n_tests++; if (ciphertext !== 128'h0) begin n_fail++; $display("FAIL reset_ciphertext: got %h, expected 0", ciphertext); end
      rst = 1'b0;
      #1;
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b, expected 1", in_ready); end
   endtask

   task automatic run_vector(input string name, input logic [127:0] key, input logic [127:0] pt,
                             input logic [127:0] exp_ct);
      int cyc;
      do_accept(pt, m_expand(key));
      wait_out(1'b1, cyc);
      n_tests++; if (cyc != 11) begin n_fail++; $display("FAIL %s_latency: got %0d clocks, expected 11", name, cyc); end
      n_tests++; if (ciphertext !== exp_ct) begin n_fail++; $display("FAIL %s_ct: got %h, expected %h", name, ciphertext, exp_ct); end
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL %s_busy_done: got %b, expected 1", name, busy); end
      do_handshake();
      n_tests++;
      if ({out_valid, busy, in_ready} !== 3'b001) begin
         n_fail++; $display("FAIL %s_after_hs: got ov/busy/ir=%b, expected 001", name, {out_valid, busy, in_ready});
      end
   endtask

   task automatic test_fips_appb(); run_vector("appb", KEY_B, PT_B, CT_B); endtask
   task automatic test_fips_c1();   run_vector("c1",   KEY_C, PT_C, CT_C); endtask

   task automatic test_backpressure();
      int cyc;
      do_accept(PT_B, m_expand(KEY_B));
      wait_out(1'b1, cyc);
      // An offered block during the hold must not be taken.
      in_valid  = 1'b1;
      plaintext = PT_C;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         n_tests++;
         if ({out_valid, in_ready, ciphertext} !== {1'b1, 1'b0, CT_B}) begin
            n_fail++;
            $display("FAIL backpressure_hold[%0d]: got ov=%b ir=%b ct=%h, expected ov=1 ir=0 ct=%h",
                     i, out_valid, in_ready, ciphertext, CT_B);
         end
      end
      in_valid = 1'b0;
      do_handshake();
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL backpressure_release: busy=%b, expected 0", busy); end
   endtask

   task automatic test_back_to_back();
      int cyc;
      out_ready = 1'b1;
      do_accept(PT_C, m_expand(KEY_C));
      @(negedge clk);
      plaintext = PT_B;
      cyc = 1;
      while (out_valid !== 1'b1 && cyc < 60) begin
         @(negedge clk);
         cyc++;
      end
      n_tests++; if (cyc != 11) begin n_fail++; $display("FAIL b2b_first_latency: got %0d, expected 11", cyc); end
      n_tests++; if (ciphertext !== CT_C) begin n_fail++; $display("FAIL b2b_first_ct: got %h, expected %h", ciphertext, CT_C); end
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready_at_hs: got %b, expected 1", in_ready); end
      round_keys = m_expand(KEY_B);
      @(posedge clk);                 // handshake of block 1 and acceptance of block 2
      wait_out(1'b0, cyc);
      n_tests++; if (cyc != 11) begin n_fail++; $display("FAIL b2b_second_latency: got %0d, expected 11", cyc); end
      n_tests++; if (ciphertext !== CT_B) begin n_fail++; $display("FAIL b2b_second_ct: got %h, expected %h", ciphertext, CT_B); end
      in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      n_tests++;
      if ({out_valid, busy} !== 2'b00) begin
         n_fail++; $display("FAIL b2b_drain: got ov/busy=%b, expected 00", {out_valid, busy});
      end
   endtask

   task automatic test_reset_mid_op();
      for (int i = 0; i < 5; i++) begin
         if (i == 0) do_accept(PT_C, m_expand(KEY_C));
         @(negedge clk);
         in_valid = 1'b0;
      end
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_before: got %b, expected 1", busy); end
      rst = 1'b1;
      #1;
      n_tests++;
      if ({busy, out_valid, in_ready} !== 3'b000 || ciphertext !== 128'h0) begin
         n_fail++;
         $display("FAIL midrst_abort: got busy/ov/ir=%b ct=%h, expected 000 and 0",
                  {busy, out_valid, in_ready}, ciphertext);
      end
      @(negedge clk);
      rst = 1'b0;
      run_vector("midrst_c1", KEY_C, PT_C, CT_C);
   endtask

   task automatic test_ignore_in_valid();
      int cyc;
      logic [127:0]  pt_a;
      logic [1407:0] rk;
      pt_a = rand128();
      rk   = m_expand(rand128());
      do_accept(pt_a, rk);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
         in_valid  = (cyc % 2 == 0) && (cyc < 9);
         plaintext = rand128();
         #1;
         if (in_valid) begin
            n_tests++;
            if (in_ready !== 1'b0) begin n_fail++; $display("FAIL run_in_ready[%0d]: got %b, expected 0", cyc, in_ready); end
         end
      end while (out_valid !== 1'b1 && cyc < 60);
      in_valid = 1'b0;
      n_tests++; if (cyc != 11) begin n_fail++; $display("FAIL run_ignore_latency: got %0d, expected 11", cyc); end
      n_tests++;
      if (ciphertext !== m_encrypt(pt_a, rk)) begin
         n_fail++; $display("FAIL run_ignore_ct: got %h, expected %h", ciphertext, m_encrypt(pt_a, rk));
      end
      do_handshake();
   endtask

   task automatic test_random();
      int cyc;
      int hold;
      logic [127:0]  pt;
      logic [127:0]  exp_ct;
      logic [1407:0] rk;
      for (int n = 0; n < 12; n++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         pt     = rand128();
         rk     = m_expand(rand128());
         exp_ct = m_encrypt(pt, rk);
         do_accept(pt, rk);
         wait_out(1'b1, cyc);
         n_tests++;
         if (out_valid !== 1'b1 || ciphertext !== exp_ct) begin
            n_fail++; $display("FAIL random[%0d]_ct: got ov=%b ct=%h, expected ov=1 ct=%h", n, out_valid, ciphertext, exp_ct);
         end
         hold = $urandom_range(0, 4);
         for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            n_tests++;
            if ({out_valid, ciphertext} !== {1'b1, exp_ct}) begin
               n_fail++; $display("FAIL random[%0d]_hold: got ov=%b ct=%h, expected ov=1 ct=%h", n, out_valid, ciphertext, exp_ct);
            end
         end
         do_handshake();
      end
   endtask

   task automatic test_protocol();
      n_tests++;
      if (proto_err != 0) begin n_fail++; $display("FAIL round_key_stability: %0d changes while busy, expected 0", proto_err); end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      build_sbox();
      test_reset();
      test_fips_appb();
      test_fips_c1();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_op();
      test_ignore_in_valid();
      test_random();
      test_protocol();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
